// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer for the 8-bit RISC CPU.
// Optional memory-wait timeout with sticky err is enabled by defining MEM_TIMEOUT_EN.
module multicycle_controller #(
  parameter int OPCODE_W     = 3,
  parameter int ALU_OP_W     = 2,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                acc_zero,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                busy,
  output logic                pc_inc,
  output logic                ir_load,
  output logic                jump,
  output logic                skip,
  output logic                mem_read,
  output logic                mem_write,
  output logic                acc_write,
  output logic                alu_to_acc,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halt,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [2:0]          op_lo;
  logic                is_nop;
  logic                waiting;
  logic                timeout;
  logic [1:0]          aop;

  assign op_lo   = op_q[2:0];
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);

  generate
    if (OPCODE_W > 3) begin : g_nop
      assign is_nop = |op_q[OPCODE_W-1:3];
    end else begin : g_no_nop
      assign is_nop = 1'b0;
    end
  endgenerate

`ifdef MEM_TIMEOUT_EN
  localparam int WCNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  logic [WCNT_W-1:0] wait_q;
  logic              err_q;

  // Fires on the wait cycle that would bring the count to MEM_WAIT_MAX; a ready
  // on that same cycle takes priority.
  assign timeout = waiting && !mem_ready && (wait_q == WCNT_W'(MEM_WAIT_MAX - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= (waiting && !mem_ready && !timeout) ? wait_q + 1'b1 : '0;
      err_q  <= err_q | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
          op_d    = opcode;
        end else if (timeout) begin
          state_d = S_HALTED;
        end
      end
      S_DECODE: begin
        if (is_nop) state_d = S_FETCH;
        else begin
          case (op_lo)
            OP_HLT:         state_d = S_HALTED;
            OP_SKZ, OP_JMP: state_d = S_FETCH;
            default:        state_d = S_MEM;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready)    state_d = (op_lo == OP_STO) ? S_FETCH : S_WB;
        else if (timeout) state_d = S_HALTED;
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Strobes decode the registered state so reset clears them immediately;
  // the fetch-complete pulses also qualify on mem_ready so PC advances once.
  always_comb begin
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    jump       = 1'b0;
    skip       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    acc_write  = 1'b0;
    alu_to_acc = 1'b0;
    aop        = 2'b00;
    halt       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        pc_inc   = mem_ready;
        ir_load  = mem_ready;
      end
      S_DECODE: begin
        jump = !is_nop && (op_lo == OP_JMP);
        skip = !is_nop && (op_lo == OP_SKZ) && acc_zero;
      end
      S_MEM: begin
        mem_write = (op_lo == OP_STO);
        mem_read  = (op_lo != OP_STO);
      end
      S_WB: begin
        acc_write  = 1'b1;
        alu_to_acc = (op_lo != OP_LDA);
        case (op_lo)
          OP_ADD:  aop = 2'b01;
          OP_AND:  aop = 2'b10;
          OP_XOR:  aop = 2'b11;
          default: aop = 2'b00;
        endcase
      end
      S_HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign state  = state_q;
  assign busy   = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign alu_op = ALU_OP_W'(aop);

endmodule
